// File: rtl/eth_pkg.sv
// Shared Ethernet CRC-32 constants and the FCS append state type.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_FCS  = 1'b1
    } fcs_state_t;

endpackage

// File: rtl/crc32_step.sv
// Combinational reflected CRC-32 update over one DW-bit beat, bit 0 first.
module crc32_step
    import eth_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [31:0]   crc_in,
    input  logic [DW-1:0] din,
    output logic [31:0]   crc_out
);

    // DW bit-serial LFSR iterations unrolled into one combinational cone
    always_comb begin
        logic [31:0] c;
        logic        fb;
        c  = crc_in;
        fb = 1'b0;
        for (int i = 0; i < DW; i++) begin
            fb = c[0] ^ din[i];
            c  = (c >> 1) ^ (fb ? CRC32_POLY_REFL : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_crc32_stream.sv
// Ethernet FCS engine: MODE=0 checks the residue of each received frame,
// MODE=1 forwards the frame and appends the complemented CRC-32.
//
// Handshake: a beat moves on an interface exactly when valid and ready are
// both high at a rising clock edge. The output side holds out_data/out_last
// stable while out_valid is high and out_ready is low. in_ready depends
// combinationally on out_ready (single output register, no skid buffer).
module eth_crc32_stream
    import eth_pkg::*;
#(
    parameter int DW   = 8,
    parameter int MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [31:0]   crc,
    output logic          done,
    output logic          ok
);

    localparam int            NBEATS   = 32 / DW;
    localparam int            CW       = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBEATS - 1);

    if (!(DW == 1 || DW == 2 || DW == 4 || DW == 8)) begin : g_bad_dw
        $error("eth_crc32_stream: DW must be 1, 2, 4 or 8");
    end
    if (!(MODE == 0 || MODE == 1)) begin : g_bad_mode
        $error("eth_crc32_stream: MODE must be 0 or 1");
    end

    fcs_state_t    state_q, state_d;
    logic [31:0]   crc_q, crc_d, crc_next;
    logic [31:0]   fcs_q, fcs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          done_q, done_d;
    logic          ok_q, ok_d;
    logic          out_free;
    logic          accept;

    crc32_step #(.DW(DW)) u_step (
        .crc_in  (crc_q),
        .din     (in_data),
        .crc_out (crc_next)
    );

    assign out_free = ~out_valid_q | out_ready;
    assign in_ready = (state_q == ST_DATA) & out_free;
    assign accept   = in_valid & in_ready;

    // Next-state and output-register logic for the data/FCS sequencer
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        fcs_d       = fcs_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q & ~out_ready;
        done_d      = 1'b0;
        ok_d        = ok_q;
        unique case (state_q)
            ST_DATA: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    crc_d       = crc_next;
                    if (MODE == 0) begin
                        // Receive: FCS beats ride through, verdict from residue
                        out_last_d = in_last;
                        if (in_last) begin
                            crc_d  = CRC32_INIT;
                            done_d = 1'b1;
                            ok_d   = (crc_next == CRC32_RESIDUE);
                        end
                    end else begin
                        // Transmit: frame end moves to the final FCS beat
                        out_last_d = 1'b0;
                        if (in_last) begin
                            fcs_d   = ~crc_next;
                            cnt_d   = '0;
                            state_d = ST_FCS;
                        end
                    end
                end
            end
            ST_FCS: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = DW'(fcs_q >> (int'(cnt_q) * DW));
                    out_last_d  = (cnt_q == CNT_LAST);
                    cnt_d       = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DATA;
                        crc_d   = CRC32_INIT;
                    end
                end
            end
            default: state_d = ST_DATA;
        endcase
    end

    // State, CRC and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_DATA;
            crc_q       <= CRC32_INIT;
            fcs_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            fcs_q       <= fcs_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign crc       = crc_q;
    assign done      = done_q;
    assign ok        = ok_q;

endmodule

// File: tb/tb_eth_crc32_stream.sv
// Bench for eth_crc32_stream: five configurations (check DW=8/2/1,
// generate DW=8/4) run side by side, each with its own driver, monitor
// and expected queues fed from a frame-level CRC-32 model.
module tb_eth_crc32_stream;

    localparam int          NCFG    = 5;
    localparam logic [31:0] INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] KAT_FCS = 32'hCBF43926;

    typedef bit         bitq_t[$];
    typedef logic [7:0] byteq_t[$];

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Textbook reflected CRC-32 register over a wire-order bit stream
    function automatic logic [31:0] crc_of_bits(input bitq_t bq);
        logic [31:0] c;
        c = INIT;
        foreach (bq[i]) begin
            c[0] = c[0] ^ bq[i];
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic bitq_t to_bits(input byteq_t by);
        bitq_t bq;
        foreach (by[i]) for (int j = 0; j < 8; j++) bq.push_back(by[i][j]);
        return bq;
    endfunction

    function automatic byteq_t rand_bytes(input int n);
        byteq_t by;
        for (int i = 0; i < n; i++) by.push_back(8'($urandom));
        return by;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int CFG  = g;
        localparam int DW   = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 1 : (g == 3) ? 8 : 4;
        localparam int MODE = (g >= 3) ? 1 : 0;
        localparam int NFCS = 32 / DW;

        logic          rst_n;
        logic [DW-1:0] in_data;
        logic          in_valid;
        logic          in_last;
        logic          in_ready;
        logic [DW-1:0] out_data;
        logic          out_valid;
        logic          out_last;
        logic          out_ready = 1'b1;
        logic [31:0]   crc;
        logic          done;
        logic          ok;

        logic [DW:0] exp_q[$];
        bit          exp_ok_q[$];
        int          done_cyc_q[$];
        bit          stall_en   = 1'b0;
        bit          held_valid = 1'b0;
        logic [DW:0] held_beat  = '0;
        int          cyc        = 0;

        eth_crc32_stream #(.DW(DW), .MODE(MODE)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (in_data),
            .in_valid  (in_valid),
            .in_last   (in_last),
            .in_ready  (in_ready),
            .out_data  (out_data),
            .out_valid (out_valid),
            .out_last  (out_last),
            .out_ready (out_ready),
            .crc       (crc),
            .done      (done),
            .ok        (ok)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Monitor: picks out_ready, then compares output beats and verdicts
        always @(negedge clk) begin
            out_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (!rst_n) begin
                held_valid = 1'b0;
            end else begin
                if (held_valid)
                    check($sformatf("cfg%0d stall hold", CFG),
                          {out_valid, out_last, out_data}, {1'b1, held_beat});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL cfg%0d out beat: got 0x%0h, expected no beat", CFG, {out_last, out_data});
                    end else begin
                        check($sformatf("cfg%0d out beat", CFG), {out_last, out_data}, exp_q.pop_front());
                    end
                    held_valid = 1'b0;
                end else begin
                    held_valid = out_valid;
                    held_beat  = {out_last, out_data};
                end
                if (done) begin
                    if (done_cyc_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL cfg%0d done pulse: got 1, expected 0", CFG);
                    end else begin
                        check($sformatf("cfg%0d done timing", CFG), cyc, done_cyc_q.pop_front());
                        check($sformatf("cfg%0d verdict ok", CFG), ok, exp_ok_q.pop_front());
                    end
                end else if (done_cyc_q.size() > 0 && done_cyc_q[0] <= cyc) begin
                    n_checks++;
                    $display("FAIL cfg%0d done pulse: got 0, expected 1 at cycle %0d", CFG, done_cyc_q[0]);
                    void'(done_cyc_q.pop_front());
                    void'(exp_ok_q.pop_front());
                end
            end
        end

        // Driver: presents one beat from a falling edge and waits for acceptance
        task automatic send_beat(input logic [DW-1:0] d, input bit last);
            int budget;
            budget = 2000;
            in_data  = d;
            in_valid = 1'b1;
            in_last  = last;
            forever begin
                #2;
                if (in_ready === 1'b1) break;
                @(negedge clk);
                budget--;
                if (budget == 0) break;
            end
            if (budget == 0) begin
                n_checks++;
                $display("FAIL cfg%0d in_ready: got 0 for 2000 cycles, expected 1", CFG);
            end else begin
                @(posedge clk);
                exp_q.push_back({last && (MODE == 0), d});
                if (last && MODE == 0) done_cyc_q.push_back(cyc + 1);
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_data  = DW'($urandom);
        endtask

        task automatic send_frame(input bitq_t bq, input int gap_max, input logic [31:0] fcs);
            int nb;
            nb = bq.size() / DW;
            for (int b = 0; b < nb; b++) begin
                logic [DW-1:0] d;
                for (int i = 0; i < DW; i++) d[i] = bq[b * DW + i];
                if (b > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
                send_beat(d, b == nb - 1);
            end
            if (MODE == 1)
                for (int k = 0; k < NFCS; k++) exp_q.push_back({k == NFCS - 1, fcs[k * DW +: DW]});
        endtask

        // Frame from payload bytes; in check mode append the model FCS, optionally corrupted
        task automatic run_frame(input byteq_t payload, input bit corrupt, input int gap_max);
            bitq_t       bq;
            logic [31:0] fcs;
            bq  = to_bits(payload);
            fcs = ~crc_of_bits(bq);
            if (MODE == 0) begin
                for (int k = 0; k < 32; k++) bq.push_back(fcs[k]);
                if (corrupt) bq[80] = ~bq[80];
                exp_ok_q.push_back(!corrupt);
            end
            send_frame(bq, gap_max, fcs);
        endtask

        task automatic run_kat();
            byteq_t      by;
            bitq_t       bq;
            logic [31:0] kat;
            string       s;
            kat = KAT_FCS;
            s   = "123456789";
            for (int i = 0; i < 9; i++) by.push_back(s[i]);
            bq = to_bits(by);
            if (MODE == 0) begin
                for (int k = 0; k < 32; k++) bq.push_back(kat[k]);
                exp_ok_q.push_back(1'b1);
            end
            send_frame(bq, 0, kat);
        endtask

        task automatic run_single_beat();
            bitq_t bq;
            for (int i = 0; i < DW; i++) bq.push_back(1'($urandom_range(0, 1)));
            if (MODE == 0) exp_ok_q.push_back(crc_of_bits(bq) == RESIDUE);
            send_frame(bq, 0, ~crc_of_bits(bq));
        endtask

        // After a stall-free frame: FCS slots block input, then idle with crc reloaded
        task automatic post_frame_idle();
            for (int k = 0; k < ((MODE == 1) ? NFCS : 0); k++) begin
                #2;
                check($sformatf("cfg%0d in_ready during FCS", CFG), in_ready, 1'b0);
                @(negedge clk);
            end
            #2;
            check($sformatf("cfg%0d in_ready idle", CFG), in_ready, 1'b1);
            check($sformatf("cfg%0d crc reloaded", CFG), crc, INIT);
            @(negedge clk);
        endtask

        task automatic run_reset_midframe();
            bitq_t bq;
            bq = to_bits(rand_bytes(60));
            for (int b = 0; b < 20; b++) begin
                logic [DW-1:0] d;
                for (int i = 0; i < DW; i++) d[i] = bq[b * DW + i];
                send_beat(d, 1'b0);
            end
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            exp_q.delete();
            done_cyc_q.delete();
            exp_ok_q.delete();
            #2;
            check($sformatf("cfg%0d out_valid after reset", CFG), out_valid, 1'b0);
            check($sformatf("cfg%0d crc after reset", CFG), crc, INIT);
            @(negedge clk);
        endtask

        // Scenario sequence for this configuration
        initial begin
            int budget;
            rst_n    = 1'b0;
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = '0;
            repeat (2) @(negedge clk);
            #2;
            check($sformatf("cfg%0d reset out_valid", CFG), out_valid, 1'b0);
            check($sformatf("cfg%0d reset out_last", CFG), out_last, 1'b0);
            check($sformatf("cfg%0d reset out_data", CFG), out_data, '0);
            check($sformatf("cfg%0d reset done", CFG), done, 1'b0);
            check($sformatf("cfg%0d reset ok", CFG), ok, 1'b0);
            check($sformatf("cfg%0d reset crc", CFG), crc, INIT);
            check($sformatf("cfg%0d reset in_ready", CFG), in_ready, 1'b1);
            rst_n = 1'b1;
            @(negedge clk);

            run_kat();
            post_frame_idle();
            run_frame(rand_bytes(60), 1'b0, 0);
            post_frame_idle();
            run_frame(rand_bytes(60), 1'b1, 1);
            post_frame_idle();
            run_frame(rand_bytes(20), 1'b0, 0);
            run_frame(rand_bytes(20), 1'b1, 0);
            run_single_beat();
            post_frame_idle();

            stall_en = 1'b1;
            repeat (4) run_frame(rand_bytes($urandom_range(11, 40)), 1'($urandom_range(0, 1)), 2);
            stall_en = 1'b0;
            budget = 3000;
            while ((exp_q.size() != 0 || done_cyc_q.size() != 0) && budget > 0) begin
                @(negedge clk);
                budget--;
            end

            run_reset_midframe();
            run_frame(rand_bytes(60), 1'b0, 0);
            post_frame_idle();

            budget = 3000;
            while ((exp_q.size() != 0 || done_cyc_q.size() != 0) && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) begin
                n_checks++;
                $display("FAIL cfg%0d drain: got %0d beats and %0d verdicts pending, expected 0",
                         CFG, exp_q.size(), done_cyc_q.size());
            end
            repeat (3) @(negedge clk);
            n_done++;
        end
    end

    // Final report once every configuration has finished
    initial begin
        int budget;
        budget = 80000;
        while (n_done < NCFG && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (n_done < NCFG) begin
            n_checks++;
            $display("FAIL global timeout: got %0d configurations finished, expected %0d", n_done, NCFG);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
